// File: rtl/alu_pipe_responder_if.sv
// Handshake bundle between the ALU requester and the pipelined ALU responder.
interface alu_pipe_responder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] selection;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [CNT_W-1:0] op_count;
  logic             dz_err;

  // Requester side: drives operands and consumes results.
  modport master (
    output in_valid, a, b, selection, out_ready,
    input  in_ready, out_valid, result, carry_out, op_count, dz_err
  );

  // Responder side: computes and returns results.
  modport slave (
    input  in_valid, a, b, selection, out_ready,
    output in_ready, out_valid, result, carry_out, op_count, dz_err
  );

endinterface

// File: rtl/alu_pipe_responder.sv
// Two-stage ALU responder: operand capture, compute-and-push into a result
// FIFO, and a registered FIFO head returned through a valid/ready handshake.
module alu_pipe_responder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  alu_pipe_responder_if.slave   bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRED_W = FCNT_W + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_DIV  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_SHL  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SHR  = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_ROTL = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_ROTR = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(10);
  localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(11);
  localparam logic [SEL_W-1:0] OP_NAND = SEL_W'(12);
  localparam logic [SEL_W-1:0] OP_XNOR = SEL_W'(13);
  localparam logic [SEL_W-1:0] OP_GT   = SEL_W'(14);
  localparam logic [SEL_W-1:0] OP_EQ   = SEL_W'(15);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] value;
  } res_t;

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;

  // Stage 2: combinational ALU result
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [PROD_W-1:0] prod_c;
  res_t             alu_res_c;
  logic             alu_dz_c;

  // Result FIFO
  res_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Registered outputs
  res_t             head_q, head_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             dz_err_q, dz_err_d;

  logic             accept_c;
  logic             push_c;
  logic             pop_c;

  // Handshake qualifiers: stage 1 always drains into the FIFO on the next edge.
  always_comb begin
    accept_c = bus.in_valid && in_ready_q;
    push_c   = s1_valid_q;
    pop_c    = out_valid_q && bus.out_ready;
  end

  // ALU evaluation of the stage-1 operands; add/sub use one extra bit for carry/borrow.
  always_comb begin
    sum_c     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_c    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    prod_c    = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
    alu_res_c = '0;
    alu_dz_c  = 1'b0;
    case (s1_sel_q)
      OP_ADD: begin
        alu_res_c.value = sum_c[WIDTH-1:0];
        alu_res_c.carry = sum_c[WIDTH];
      end
      OP_SUB: begin
        alu_res_c.value = diff_c[WIDTH-1:0];
        alu_res_c.carry = diff_c[WIDTH];
      end
      OP_MUL: begin
        alu_res_c.value = prod_c[WIDTH-1:0];
        alu_res_c.carry = |prod_c[PROD_W-1:WIDTH];
      end
      OP_DIV: begin
        if (s1_b_q == '0) begin
          alu_res_c.value = '1;
          alu_res_c.carry = 1'b1;
          alu_dz_c        = 1'b1;
        end else begin
          alu_res_c.value = s1_a_q / s1_b_q;
        end
      end
      OP_SHL: begin
        alu_res_c.value = {s1_a_q[WIDTH-2:0], 1'b0};
        alu_res_c.carry = s1_a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_c.value = {1'b0, s1_a_q[WIDTH-1:1]};
        alu_res_c.carry = s1_a_q[0];
      end
      OP_ROTL: alu_res_c.value = {s1_a_q[WIDTH-2:0], s1_a_q[WIDTH-1]};
      OP_ROTR: alu_res_c.value = {s1_a_q[0], s1_a_q[WIDTH-1:1]};
      OP_AND:  alu_res_c.value = s1_a_q & s1_b_q;
      OP_OR:   alu_res_c.value = s1_a_q | s1_b_q;
      OP_XOR:  alu_res_c.value = s1_a_q ^ s1_b_q;
      OP_NOR:  alu_res_c.value = ~(s1_a_q | s1_b_q);
      OP_NAND: alu_res_c.value = ~(s1_a_q & s1_b_q);
      OP_XNOR: alu_res_c.value = ~(s1_a_q ^ s1_b_q);
      OP_GT:   alu_res_c.value = WIDTH'(s1_a_q > s1_b_q);
      OP_EQ:   alu_res_c.value = WIDTH'(s1_a_q == s1_b_q);
      default: alu_res_c = '0;
    endcase
  end

  // Next-state for stage 1, FIFO bookkeeping and the registered outputs.
  always_comb begin
    s1_valid_d = accept_c;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    if (accept_c) begin
      s1_a_d   = bus.a;
      s1_b_d   = bus.b;
      s1_sel_d = bus.selection;
    end

    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q + FCNT_W'(push_c) - FCNT_W'(pop_c);

    // Head tracks the oldest entry; a push into an empty (or draining-to-empty)
    // FIFO bypasses the memory. An empty FIFO keeps the last popped value.
    head_d = head_q;
    if (fcnt_d != '0) begin
      if ((fcnt_q == '0) || (pop_c && (fcnt_q == FCNT_W'(1)))) begin
        head_d = alu_res_c;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    out_valid_d = (fcnt_d != '0);
    // Credit: every result in flight or buffered holds a FIFO slot.
    in_ready_d  = (CRED_W'(fcnt_d) + CRED_W'(s1_valid_d)) < CRED_W'(FIFO_DEPTH);
    op_count_d  = op_count_q + CNT_W'(pop_c);
    dz_err_d    = dz_err_q | (push_c & alu_dz_c);
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= '0;
      dz_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
      dz_err_q    <= dz_err_d;
    end
  end

  // FIFO storage; contents are only meaningful behind the count, so no reset.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= alu_res_c;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = head_q.value;
  assign bus.carry_out = head_q.carry;
  assign bus.op_count  = op_count_q;
  assign bus.dz_err    = dz_err_q;

  // The credit rule must keep the FIFO from overfilling.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    fcnt_q <= FCNT_W'(FIFO_DEPTH));

  // A stalled head must not change under the consumer.
  a_head_stable: assert property (@(posedge clock) disable iff (reset)
    (out_valid_q && !bus.out_ready) |=> (head_q == $past(head_q)));

endmodule

// File: doc/alu_pipe_responder.md
Name: alu_pipe_responder

Overview:
Responder end of the ALU stimulus interface. It accepts operand/opcode transactions (a, b, selection) through a valid/ready handshake and computes them in a registered two-stage pipeline. Results (result, carry_out) are buffered in an output FIFO and returned through a valid/ready handshake. It is the synthesizable counterpart the drv/mon agents exercise, and the block adds backpressure.

Parameters:
WIDTH, 8, operand/result width (a, b, result)
SEL_W, 4, opcode width
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, completed-operation counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
selection  input  SEL_W  opcode
out_valid  output  1  FIFO head holds a result
out_ready  input  1  consumer takes head this cycle
result  output  WIDTH  FIFO head result
carry_out  output  1  FIFO head carry/flag
op_count  output  CNT_W  results popped since reset
dz_err  output  1  sticky: a divide-by-zero was executed

Behaviour:
- Reset (async assert, synchronous release on clock): FIFO empty, pipeline stage invalid. out_valid=0, result=0, carry_out=0, op_count=0, dz_err=0, in_ready=1 on the first cycle after release.
- Accept: in_valid&&in_ready at edge k captures a, b, selection into stage 1. Edge k+1 computes the result and writes it to the FIFO. If the FIFO was empty, out_valid=1 in the cycle after edge k+1, giving a latency of 2 edges.
- in_ready = (fifo_count + stage1_valid) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows, and it does not depend on out_ready in the same cycle.
- Pop: out_valid&&out_ready at an edge removes the head, and op_count increments (wraps at 2^CNT_W).
- A simultaneous push and pop leaves the count unchanged, with FIFO order preserved.
- With a full FIFO and no pop, in_ready=0. Inputs are ignored while in_ready=0.
- result and carry_out show the FIFO head. When empty, they hold the last popped value; their value is don't-care while out_valid=0.
- result and carry_out must stay stable while out_valid=1 and out_ready=0.
- Opcodes (9-bit internal for add/sub):
  - 0 add: result=a+b; carry=bit 8.
  - 1 sub: result=a-b; carry=(a<b) borrow.
  - 2 mul: result=low byte of a*b; carry=(high byte!=0).
  - 3 div: result=a/b; carry=0. If b=0: result=all-ones, carry=1, dz_err set.
  - 4 shl1: result=a<<1; carry=a[MSB].
  - 5 shr1: result=a>>1; carry=a[0].
  - 6 rotl1; 7 rotr1: carry=0.
  - 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor: carry=0.
  - 14 gt: result=(a>b)?1:0.
  - 15 eq: result=(a==b)?1:0. carry=0 for both.
- All arithmetic is unsigned.
- dz_err is set at the edge where a div-by-zero result enters the FIFO. It is cleared only by reset.
- Reset mid-operation: in-flight and buffered results are discarded with no partial output. op_count and dz_err clear.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the count, not from pointer equality alone.

Test Plan:
- Single op: a=8'hF0, b=8'h20, sel=0 accepted at edge k -> out_valid after edge k+1, result=8'h10, carry_out=1, op_count=1 after pop.
- Opcode sweep, a=8'h81, b=8'h03, out_ready=1:
  - sub -> 7E/0; mul -> 83/1; div -> 2B/0; shl1 -> 02/1; shr1 -> 40/1.
  - rotl1 -> 03/0; rotr1 -> C0/0; gt -> 01/0; eq -> 00/0.
- Div by zero: a=8'h05, b=0, sel=3 -> result=8'hFF, carry_out=1, dz_err=1 and stays 1 through further ops.
- Backpressure: out_ready=0, issue 6 back-to-back ops -> in_ready drops after exactly FIFO_DEPTH (4) accepts. Then set out_ready=1 -> 4 results pop in order, remaining ops accepted, no loss or duplication.
- Simultaneous push/pop: steady streaming with in_valid=out_ready=1 -> one result per cycle, in_ready stays 1, op_count increments every cycle after fill.
- Async reset mid-stream: assert reset between edges with 3 results buffered -> out_valid=0, op_count=0, dz_err=0 immediately. After release, in_ready=1 and the next op returns only its own result.
